// File: rtl/boot_loader_ctrl.sv
// Bootloader controller: parses DEST/ADDR/CNT headers from a UART byte stream and assembles
// payload bytes into I-mem, D-mem or image-buffer words, each issued as a one-cycle write strobe.
module boot_loader_ctrl #(
  parameter int unsigned IB_DW  = 3072,
  parameter int unsigned MEM_DW = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              abort,
  output logic              boot_active,
  output logic              imem_we,
  output logic              dmem_we,
  output logic              ib_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IB_DW-1:0]  wr_data,
  output logic              done,
  output logic              err
);

  localparam int unsigned IB_BYTES  = IB_DW / 8;
  localparam int unsigned MEM_BYTES = MEM_DW / 8;
  localparam int unsigned IDX_W     = $clog2(IB_BYTES);

  typedef enum logic [2:0] {StIdle, StALo, StAHi, StCLo, StCHi, StData} state_e;

  state_e              state_q, state_d;
  logic [2:0]          dest_q, dest_d;     // one-hot {imem, dmem, ib}
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IB_DW-1:0]    data_q, data_d;
  logic [2:0]          we_q, we_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                dest_ok;
  logic                word_last;
  logic [ADDR_W-1:0]   cnt_hdr;

  assign dest_ok   = (rx_data == 8'h04) || (rx_data == 8'h02) || (rx_data == 8'h01);
  assign word_last = dest_q[0] ? (idx_q == IDX_W'(IB_BYTES - 1))
                               : (idx_q == IDX_W'(MEM_BYTES - 1));
  assign cnt_hdr   = {rx_data[ADDR_W-9:0], cnt_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dest_q   <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      we_q     <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      we_q     <= we_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    we_d     = '0;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Address advances as the write strobe retires; header bytes below may then overwrite it.
    if (|we_q) addr_d = addr_q + 1'b1;

    if (abort) begin
      state_d  = StIdle;
      active_d = 1'b0;
      idx_d    = '0;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (dest_ok) begin
            dest_d   = rx_data[2:0];
            active_d = 1'b1;
            state_d  = StALo;
          end else begin
            err_d = 1'b1;
          end
        end
        StALo: begin
          addr_d[7:0] = rx_data;
          state_d     = StAHi;
        end
        StAHi: begin
          addr_d[ADDR_W-1:8] = rx_data[ADDR_W-9:0];
          state_d            = StCLo;
        end
        StCLo: begin
          cnt_d[7:0] = rx_data;
          state_d    = StCHi;
        end
        StCHi: begin
          cnt_d = cnt_hdr;
          idx_d = '0;
          if (cnt_hdr == '0) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = StIdle;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          data_d[8*idx_q +: 8] = rx_data;
          if (word_last) begin
            idx_d = '0;
            we_d  = dest_q;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == ADDR_W'(1)) begin
              done_d   = 1'b1;
              active_d = 1'b0;
              state_d  = StIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign boot_active = active_q;
  assign imem_we     = we_q[2];
  assign dmem_we     = we_q[1];
  assign ib_we       = we_q[0];
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
